pipe_stall_ctrl: RTL

//  Responder side of the load-use hazard handshake. Consumes ex_bubble, pc_write
//  and ifid_write from the hazard detection unit, and applies them to the front
//  of the 5-stage MIPS pipe: owns the PC register, the IF/ID register and the

---
 rtl/pipe_stall_ctrl_pkg.sv | 13 +
 rtl/pipe_stall_ctrl_sat_counter.sv | 16 +
 rtl/pipe_stall_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared front-end pipeline definitions: NOP encoding, PC step, action/state codes.
package pipe_stall_ctrl_pkg;
  localparam logic [31:0] NOP_INSTR  = 32'h0;
  localparam int          PC_STEP    = 4;
  localparam int          CTRL_W_DEF = 9;
  localparam int          CS_W       = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter used for stall/flush statistics; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Front-of-pipe responder for the load-use hazard handshake: owns PC, IF/ID and
// the ID/EX control field, applies branch flushes and flags contract violations.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              CTRL_W    = CTRL_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              CNT_W     = 16,
  parameter int              MAX_STALL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   imem_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_bubble,
  input  logic              pc_write,
  input  logic              ifid_write,
  input  logic              ex_branch_taken,
  input  logic [PC_W-1:0]   ex_branch_target,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   ifid_instr,
  output logic [PC_W-1:0]   ifid_pc4,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic [1:0]        fsm_state,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic              protocol_err
);
  localparam logic [CS_W-1:0] MAX_C = CS_W'(MAX_STALL);

  state_e          state;
  logic [CS_W-1:0] consec_stall;
  logic            is_flush, is_stall, stall_over, viol;
  logic [PC_W-1:0] pc_plus4;

  always_comb begin
    is_flush   = ex_branch_taken;
    is_stall   = !ex_branch_taken && (!pc_write || !ifid_write);
    // this stall would push the run of back-to-back stalls past the limit
    stall_over = is_stall && (consec_stall >= MAX_C);
    viol       = (pc_write != ifid_write) || (ex_bubble == pc_write) || stall_over;
    pc_plus4   = pc + PC_W'(PC_STEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      pc           <= RESET_PC;
      ifid_instr   <= PC_W'(NOP_INSTR);
      ifid_pc4     <= '0;
      idex_ctrl    <= '0;
      consec_stall <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (viol)
        protocol_err <= 1'b1;
      if (is_flush) begin
        state        <= ST_FLUSH;
        pc           <= ex_branch_target;
        ifid_instr   <= PC_W'(NOP_INSTR);
        ifid_pc4     <= '0;
        idex_ctrl    <= '0;
        consec_stall <= '0;
      end else if (is_stall) begin
        state     <= ST_STALL;
        idex_ctrl <= '0;
        if (consec_stall != '1)
          consec_stall <= consec_stall + CS_W'(1);
      end else begin
        state        <= ST_RUN;
        pc           <= pc_plus4;
        ifid_instr   <= imem_instr;
        ifid_pc4     <= pc_plus4;
        idex_ctrl    <= ex_bubble ? '0 : id_ctrl;
        consec_stall <= '0;
      end
    end
  end

  assign fsm_state = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(is_stall), .count(stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(is_flush), .count(flush_count)
  );
endmodule
